// File: rtl/univ_shift_register.sv
// univ_shift_register: parametrised universal shift register.
// Parallel load, single-step left/right shifts with serial or rotate fill,
// and a multi-bit burst shift engine with a busy/done handshake.
// Optional feature macro: USR_ARITH_SHIFT_EN (arithmetic right-shift fill).
module univ_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_left,
  input  logic             shift_right,
  input  logic             serial_in,
  input  logic             rotate,
  input  logic             load,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic             dir,
  input  logic [AMT_W-1:0] amount,
  input  logic             arith,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE     = 1'b0,
    SHIFTING = 1'b1
  } state_t;

  state_t           state;
  logic [AMT_W-1:0] cnt;
  logic             lat_dir;
  logic             lat_rot;

  logic             step_right;
  logic             step_rot;
  logic             fill;
  logic [WIDTH-1:0] step_data;
  logic             step_out;

`ifdef USR_ARITH_SHIFT_EN
  logic             lat_arith;
  logic             step_arith;
`else
  logic             unused_arith;
  assign unused_arith = arith;
`endif

  // One-step shift datapath; a burst uses its latched controls, idle uses live ones
  always_comb begin
    step_right = (state == SHIFTING) ? lat_dir : shift_right;
    step_rot   = (state == SHIFTING) ? lat_rot : rotate;
`ifdef USR_ARITH_SHIFT_EN
    step_arith = (state == SHIFTING) ? lat_arith : arith;
`endif
    fill      = serial_in;
    step_out  = 1'b0;
    step_data = data_out;
    if (step_right) begin
      step_out = data_out[0];
      fill     = step_rot ? data_out[0] : serial_in;
`ifdef USR_ARITH_SHIFT_EN
      if (!step_rot && step_arith) begin
        fill = data_out[WIDTH-1];
      end
`endif
      step_data = {fill, data_out[WIDTH-1:1]};
    end else begin
      step_out  = data_out[WIDTH-1];
      fill      = step_rot ? data_out[WIDTH-1] : serial_in;
      step_data = {data_out[WIDTH-2:0], fill};
    end
  end

  // Control FSM, register contents and handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      data_out   <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      lat_dir    <= 1'b0;
      lat_rot    <= 1'b0;
`ifdef USR_ARITH_SHIFT_EN
      lat_arith  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            data_out <= par_in;
          end else if (start) begin
            lat_dir   <= dir;
            lat_rot   <= rotate;
`ifdef USR_ARITH_SHIFT_EN
            lat_arith <= arith;
`endif
            if (amount != '0) begin
              busy  <= 1'b1;
              cnt   <= amount;
              state <= SHIFTING;
            end else begin
              done <= 1'b1;
            end
          end else if (shift_left ^ shift_right) begin
            data_out   <= step_data;
            serial_out <= step_out;
          end
        end
        SHIFTING: begin
          if (load) begin
            data_out <= par_in;
            busy     <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            data_out   <= step_data;
            serial_out <= step_out;
            cnt        <= cnt - AMT_W'(1);
            if (cnt == AMT_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_register.sv
// Testbench for univ_shift_register (WIDTH=8, AMT_W=4): directed steps from
// the test plan followed by randomized traffic, checked against a behavioural
// model that computes shifts with plain integer arithmetic.
module tb_univ_shift_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift_left, shift_right, serial_in, rotate, load, start, dir, arith;
  logic [7:0] par_in;
  logic [3:0] amount;
  logic [7:0] data_out;
  logic       serial_out, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_data, m_sout, m_busy, m_done, m_left, m_dir, m_rot, m_ar;

  univ_shift_register #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .rst(rst), .shift_left(shift_left), .shift_right(shift_right),
    .serial_in(serial_in), .rotate(rotate), .load(load), .par_in(par_in),
    .start(start), .dir(dir), .amount(amount), .arith(arith),
    .data_out(data_out), .serial_out(serial_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic idle_in();
    shift_left = 0; shift_right = 0; serial_in = 0; rotate = 0; load = 0;
    start = 0; dir = 0; arith = 0; par_in = 8'h00; amount = 4'd0;
  endtask

  task automatic model_reset();
    m_data = 0; m_sout = 0; m_busy = 0; m_done = 0; m_left = 0;
    m_dir = 0; m_rot = 0; m_ar = 0;
  endtask

  // one shift by arithmetic: left = *2 mod 256 + fill, right = /2 + fill*128
  task automatic model_step(input int right, input int rot, input int ar);
    int out, f;
    if (right == 0) begin
      out = m_data / 128;
      f   = rot ? out : int'(serial_in);
      m_data = (m_data * 2) % 256 + f;
    end else begin
      out = m_data % 2;
      f   = rot ? out : int'(serial_in);
`ifdef USR_ARITH_SHIFT_EN
      if (!rot && ar != 0) f = m_data / 128;
`endif
      m_data = m_data / 2 + f * 128;
    end
    m_sout = out;
  endtask

  task automatic model_edge();
    m_done = 0;
    if (m_busy == 0) begin
      if (load) m_data = int'(par_in);
      else if (start) begin
        m_dir = int'(dir); m_rot = int'(rotate); m_ar = int'(arith);
        if (amount != 0) begin m_busy = 1; m_left = int'(amount); end
        else m_done = 1;
      end else if (shift_left != shift_right) model_step(int'(shift_right), int'(rotate), int'(arith));
    end else begin
      if (load) begin m_data = int'(par_in); m_busy = 0; m_left = 0; end
      else begin
        model_step(m_dir, m_rot, m_ar);
        m_left = m_left - 1;
        if (m_left == 0) begin m_busy = 0; m_done = 1; end
      end
    end
  endtask

  task automatic check(input string tag);
    n_tests++;
    assert (data_out === 8'(m_data)) else begin
      n_fail++; $error("FAIL %s data_out got %h exp %h", tag, data_out, 8'(m_data));
    end
    n_tests++;
    assert (serial_out === 1'(m_sout)) else begin
      n_fail++; $error("FAIL %s serial_out got %b exp %b", tag, serial_out, 1'(m_sout));
    end
    n_tests++;
    assert (busy === 1'(m_busy)) else begin
      n_fail++; $error("FAIL %s busy got %b exp %b", tag, busy, 1'(m_busy));
    end
    n_tests++;
    assert (done === 1'(m_done)) else begin
      n_fail++; $error("FAIL %s done got %b exp %b", tag, done, 1'(m_done));
    end
  endtask

  task automatic check_data(input string tag, input logic [7:0] exp);
    n_tests++;
    assert (data_out === exp) else begin
      n_fail++; $error("FAIL %s data_out got %h exp %h", tag, data_out, exp);
    end
  endtask

  // advance one clock, update model, sample 1 time unit after the edge
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) model_reset(); else model_edge();
    #1;
    check(tag);
  endtask

  initial begin
    logic [7:0] exp6;
    int seen_done;
    idle_in();
    model_reset();
    rst = 0;

    // 1. reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      load = 1'(i); par_in = 8'hFF; shift_left = 1; start = 1'(i >> 1); amount = 4'd3;
      tick("reset_hold");
    end
    idle_in();
    @(negedge clk); rst = 1;
    tick("post_reset_idle");
    check_data("post_reset_zero", 8'h00);

    // 2. load, left shift with serial_in=1, both-direction hold
    load = 1; par_in = 8'hA5; tick("load_a5"); check_data("load_a5_val", 8'hA5);
    idle_in(); shift_left = 1; serial_in = 1; tick("shl_a5"); check_data("shl_a5_val", 8'h4B);
    idle_in(); shift_left = 1; shift_right = 1; serial_in = 1; tick("both_hold");
    check_data("both_hold_val", 8'h4B);

    // 3. rotate right then left
    idle_in(); load = 1; par_in = 8'h81; tick("load_81");
    idle_in(); shift_right = 1; rotate = 1; tick("rotr"); check_data("rotr_val", 8'hC0);
    idle_in(); shift_left = 1; rotate = 1; tick("rotl"); check_data("rotl_val", 8'h81);

    // 4. burst left by 3 with ignored shift_left pulses
    idle_in(); load = 1; par_in = 8'h01; tick("load_01");
    idle_in(); start = 1; dir = 0; amount = 4'd3; tick("burst_start");
    idle_in(); shift_left = 1; tick("burst_s1"); check_data("burst_s1_val", 8'h02);
    idle_in(); shift_left = 1; start = 1; amount = 4'd7; tick("burst_s2");
    check_data("burst_s2_val", 8'h04);
    idle_in(); tick("burst_s3"); check_data("burst_s3_val", 8'h08);
    tick("burst_after");

    // 5. load aborts burst; amount=0 pulse
    idle_in(); start = 1; dir = 0; amount = 4'd5; tick("abort_start");
    idle_in(); tick("abort_s1"); tick("abort_s2");
    load = 1; par_in = 8'h3C; tick("abort_load"); check_data("abort_load_val", 8'h3C);
    idle_in(); tick("abort_after1"); tick("abort_after2");
    start = 1; amount = 4'd0; tick("zero_start");
    idle_in(); tick("zero_after");

    // 6. arithmetic right shift select
    idle_in(); load = 1; par_in = 8'h90; tick("load_90");
    idle_in(); shift_right = 1; arith = 1; serial_in = 0; tick("arith_shr");
`ifdef USR_ARITH_SHIFT_EN
    exp6 = 8'hC8;
`else
    exp6 = 8'h48;
`endif
    check_data("arith_shr_val", exp6);

    // back-to-back start in the cycle done is high
    idle_in(); start = 1; dir = 1; amount = 4'd1; serial_in = 1; tick("b2b_a");
    tick("b2b_b");
    tick("b2b_c");
    idle_in(); tick("b2b_d"); tick("b2b_e");

    // asynchronous reset mid-burst: immediate clear, no done afterwards
    start = 1; dir = 0; amount = 4'd9; tick("rst_mid_start");
    idle_in(); tick("rst_mid_s1");
    #2 rst = 0; #1;
    model_reset();
    check("rst_async");
    tick("rst_held");
    @(negedge clk); rst = 1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick("rst_after");
      if (done) seen_done = 1;
    end
    n_tests++;
    assert (seen_done === 0) else begin
      n_fail++; $error("FAIL rst_no_done got %0d exp %0d", seen_done, 0);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      shift_left  = 1'($urandom_range(0, 1));
      shift_right = 1'($urandom_range(0, 1));
      serial_in   = 1'($urandom_range(0, 1));
      rotate      = 1'($urandom_range(0, 3) == 0);
      arith       = 1'($urandom_range(0, 1));
      load        = 1'($urandom_range(0, 15) == 0);
      par_in      = 8'($urandom);
      start       = 1'($urandom_range(0, 5) == 0);
      dir         = 1'($urandom_range(0, 1));
      amount      = 4'($urandom_range(0, 15));
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/univ_shift_register.md
Name: univ_shift_register

Overview:
Parametrised universal shift register that succeeds the fixed 4-bit left/right shifter.
- Supports WIDTH-bit data, parallel load, serial or rotate fill, and a multi-bit burst shift engine with busy/done handshake.
- Sits in datapath serialisers and bit-manipulation paths.
- Single-step control uses the same shift_left/shift_right/serial_in semantics as the existing shifter.

Parameters:
WIDTH, 8, register width in bits (>=2)
AMT_W, 4, width of burst shift amount; max burst = 2^AMT_W-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
shift_left  input  1  single-step shift toward MSB
shift_right  input  1  single-step shift toward LSB
serial_in  input  1  fill bit for non-rotate shifts
rotate  input  1  1 = fill with wrapped-out bit instead of serial_in
load  input  1  parallel load strobe
par_in  input  WIDTH  parallel load data
start  input  1  burst request, sampled when idle
dir  input  1  burst direction: 0 = left, 1 = right
amount  input  AMT_W  burst shift count
arith  input  1  arithmetic right shift select (see Optional Feature)
data_out  output  WIDTH  register contents
serial_out  output  1  last bit shifted out
busy  output  1  burst in progress
done  output  1  one-cycle burst completion pulse

Behaviour:
- Reset (rst=0, async): data_out=0, serial_out=0, busy=0, done=0, burst counter=0, state IDLE. A reset mid-burst aborts the burst immediately and produces no done.
- Left step: data <= {data[W-2:0], fill}, where fill = rotate ? data[W-1] : serial_in. serial_out <= data[W-1].
- Right step: data <= {fill, data[W-1:1]}, where fill = rotate ? data[0] : serial_in. serial_out <= data[0].
- States are IDLE and SHIFTING.
- IDLE priority, evaluated per edge:
  - load: data <= par_in; serial_out unchanged.
  - else start: handled as a burst request (see burst rules below).
  - else shift_left XOR shift_right: one step in the asserted direction.
  - shift_left and shift_right both high: hold, no change.
  - nothing asserted: hold.
- Burst request at edge k:
  - amount, dir and rotate are latched at edge k.
  - amount>0: busy <= 1, counter <= amount, go to SHIFTING.
  - amount=0: done <= 1 at edge k, busy stays 0, no shift.
- SHIFTING:
  - One step per edge, using the latched dir and rotate. serial_in is sampled live each edge.
  - Shifts occur at edges k+1 .. k+N.
  - At edge k+N: busy <= 0, done <= 1, return to IDLE. done is cleared at edge k+N+1.
  - While busy, shift_left, shift_right and start are ignored.
  - load while busy: data <= par_in, busy <= 0, return to IDLE, no done pulse.
- done is never high for more than one cycle. A new start in the cycle done is high is accepted normally.
- All outputs are registered. Single-step latency is 1 cycle.

Optional Feature:
Macro USR_ARITH_SHIFT_EN.
- Defined: a right step (single or burst) with arith=1 and rotate=0 uses fill = data[W-1] (sign replication). arith is latched with dir at burst start. arith has no effect on left shifts or rotates.
- Undefined: the arith port exists but is ignored; right-shift fill follows the base rules.

Test Plan:
1. WIDTH=8. Hold rst=0 with inputs toggling -> data_out=8'h00, serial_out=0, busy=0, done=0. Release -> outputs stay 0 until the first command.
2. load, par_in=8'hA5 -> data_out=8'hA5. Then shift_left with serial_in=1 -> 8'h4B, serial_out=1. Then shift_left and shift_right together -> holds 8'h4B.
3. data=8'h81, shift_right, rotate=1 -> 8'hC0, serial_out=1. Then shift_left, rotate=1 -> 8'h81.
4. data=8'h01, start with dir=0, amount=3, serial_in=0 at edge k -> busy high during edges k..k+3. data 02, 04, 08 after edges k+1..k+3. done high only between edges k+3 and k+4. shift_left pulses during the burst have no effect.
5. Start with amount=5, then load par_in=8'h3C after the 2nd shift -> data_out=8'h3C, busy=0, done never asserted. Also: start with amount=0 -> done pulse after one edge, data unchanged, busy never high.
6. data=8'h90, shift_right with arith=1, serial_in=0 -> 8'hC8 with USR_ARITH_SHIFT_EN defined; 8'h48 without it.
